// File: rtl/nlms_weight_update_if.sv
// Handshake and data bundle between the adaptive filter and its NLMS weight updater.
// The filter side is master, the updater is slave.
interface nlms_weight_update_if #(
  parameter int TAPS  = 32,
  parameter int REF_W = 14,
  parameter int E_W   = 14,
  parameter int W_W   = 16,
  parameter int N_W   = 32
);
  logic                    start;
  logic                    wclr;
  logic signed [E_W-1:0]   err;
  logic [N_W-1:0]          norm;
  logic [TAPS*REF_W-1:0]   ref_flat;
  logic [TAPS*W_W-1:0]     w_flat;
  logic                    busy;
  logic                    done;

  modport master (
    output start, wclr, err, norm, ref_flat,
    input  w_flat, busy, done
  );

  modport slave (
    input  start, wclr, err, norm, ref_flat,
    output w_flat, busy, done
  );
endinterface

// File: rtl/nlms_weight_update.sv
// Normalised-LMS tap-weight store: one serial pass per start, one tap per cycle
// through a multiply stage and a shift/accumulate/saturate stage.
//
// state | meaning
// IDLE  | waiting; start launches a pass, wclr zeroes the weights
// CAPT  | derive nshift = floor(log2(norm)) and the norm==0 skip flag
// UPD   | k = 0..TAPS: stage 1 multiplies tap k, stage 2 writes tap k-1
// FIN   | pass complete; done pulses on the following cycle
module nlms_weight_update #(
  parameter int TAPS     = 32,
  parameter int REF_W    = 14,
  parameter int E_W      = 14,
  parameter int W_W      = 16,
  parameter int N_W      = 32,
  parameter int FRAC     = 10,
  parameter int MU_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rstn,
  nlms_weight_update_if.slave bus
);

  localparam int P_W = E_W + REF_W;
  localparam int X_W = 48;
  localparam int KW  = $clog2(TAPS + 1);
  localparam int IW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int SW  = $clog2(N_W);

  typedef enum logic [1:0] {IDLE, CAPT, UPD, FIN} state_t;

  state_t                 state, state_nx;
  logic signed [E_W-1:0]  err_q;
  logic [N_W-1:0]         norm_q;
  logic [SW-1:0]          nshift_q, nshift_c;
  logic                   skip_q;
  logic [KW-1:0]          k_q;
  logic [IW-1:0]          j_q;
  logic signed [P_W-1:0]  p_q;
  logic                   busy_q, done_q;

  logic signed [W_W-1:0]   w       [TAPS];
  logic signed [REF_W-1:0] ref_arr [TAPS];
  logic signed [REF_W-1:0] ref_sel;
  logic signed [W_W-1:0]   w_cur, w_new;
  logic signed [X_W-1:0]   p_ext, delta, s;
  logic [6:0]              shamt;
  logic                    wr_en;

  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    assign ref_arr[g]                 = bus.ref_flat[g*REF_W +: REF_W];
    assign bus.w_flat[g*W_W +: W_W]   = w[g];
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CAPT;
      CAPT:    state_nx = UPD;
      UPD:     if (k_q == KW'(TAPS)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    nshift_c = '0;
    for (int i = 0; i < N_W; i++)
      if (norm_q[i]) nshift_c = SW'(i);
  end

  // At k == TAPS the low index bits wrap to 0; that product is never written back.
  assign ref_sel = ref_arr[k_q[IW-1:0]];

  always_comb begin
    w_cur = w[j_q];
    p_ext = $signed({{(X_W-P_W){p_q[P_W-1]}}, p_q});
    shamt = 7'(MU_SHIFT) + 7'(nshift_q);
    delta = (p_ext <<< FRAC) >>> shamt;
    s     = $signed({{(X_W-W_W){w_cur[W_W-1]}}, w_cur}) + delta;
    w_new = s[W_W-1:0];
    if (s > $signed({{(X_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}}))
      w_new = {1'b0, {(W_W-1){1'b1}}};
    else if (s < $signed({{(X_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}}))
      w_new = {1'b1, {(W_W-1){1'b0}}};
    wr_en = (state == UPD) && (k_q != '0) && !skip_q;
  end

  // busy/done are registered from the current state, so busy stays high
  // through the done cycle and drops one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      err_q    <= '0;
      norm_q   <= '0;
      nshift_q <= '0;
      skip_q   <= 1'b0;
      k_q      <= '0;
      j_q      <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state != IDLE);
      done_q <= (state == FIN);
      case (state)
        IDLE: if (bus.start) begin
          err_q  <= bus.err;
          norm_q <= bus.norm;
        end
        CAPT: begin
          nshift_q <= nshift_c;
          skip_q   <= (norm_q == '0);
          k_q      <= '0;
        end
        UPD: begin
          k_q <= k_q + KW'(1);
          if (k_q < KW'(TAPS)) begin
            p_q <= $signed({{REF_W{err_q[E_W-1]}}, err_q}) *
                   $signed({{E_W{ref_sel[REF_W-1]}}, ref_sel});
            j_q <= k_q[IW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
    end else if (state == IDLE && !bus.start && bus.wclr) begin
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
    end else if (wr_en) begin
      w[j_q] <= w_new;
    end
  end

endmodule

// File: tb/tb_nlms_weight_update.sv
// Directed bench for nlms_weight_update: a table of update passes with
// hand-computed weights, plus reset, wclr and mid-pass reset sequences.
module tb_nlms_weight_update;

  localparam int TAPS  = 32;
  localparam int REF_W = 14;
  localparam int W_W   = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nlms_weight_update_if bus ();
  nlms_weight_update dut (.clk(clk), .rstn(rstn), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          clr;     // pulse wclr in IDLE before the pass
    bit          both;    // raise wclr together with start
    bit          inj;     // pulse start+wclr at cycle 10 of the pass
    int          err;
    logic [31:0] norm;
    int          base;    // ref value on every tap except k
    int          k;
    int          kv;      // ref value on tap k
    int          exp_all; // expected weight on every tap except k
    int          exp_k;   // expected weight on tap k
  } vec_t;

  vec_t tv [12];

  function automatic int wt(input int j);
    logic signed [W_W-1:0] v;
    v = bus.w_flat[j*W_W +: W_W];
    return int'(v);
  endfunction

  task automatic run_pass(input int vi);
    vec_t v;
    int   prev [TAPS];
    int   last [TAPS];
    int   chg_cnt [TAPS];
    int   chg_cyc [TAPS];
    int   done_cnt, done_cyc, busy_rise, busy_fall, e;
    v = tv[vi];
    if (v.clr) begin
      @(negedge clk);
      bus.wclr = 1'b1;
      @(posedge clk);
      #1 bus.wclr = 1'b0;
      chk($sformatf("wclr zero v%0d", vi), longint'(bus.w_flat == '0), 1);
    end
    @(negedge clk);
    bus.err  = 14'(v.err);
    bus.norm = v.norm;
    for (int i = 0; i < TAPS; i++)
      bus.ref_flat[i*REF_W +: REF_W] = 14'((i == v.k) ? v.kv : v.base);
    for (int i = 0; i < TAPS; i++) begin
      prev[i] = wt(i); last[i] = prev[i]; chg_cnt[i] = 0; chg_cyc[i] = -1;
    end
    bus.start = 1'b1;
    bus.wclr  = v.both;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wclr  = 1'b0;
    done_cnt = 0; done_cyc = -1; busy_rise = -1; busy_fall = -1;
    chk($sformatf("busy c0 v%0d", vi), longint'(bus.busy), 0);
    for (int c = 1; c <= 40; c++) begin
      if (v.inj && c == 10) begin bus.start = 1'b1; bus.wclr = 1'b1; end
      @(posedge clk);
      #1;
      if (v.inj && c == 10) begin bus.start = 1'b0; bus.wclr = 1'b0; end
      if (bus.done) begin done_cnt++; done_cyc = c; end
      if (bus.busy && busy_rise < 0) busy_rise = c;
      if (!bus.busy && busy_rise >= 0 && busy_fall < 0) busy_fall = c;
      for (int j = 0; j < TAPS; j++)
        if (wt(j) != last[j]) begin
          chg_cnt[j]++; chg_cyc[j] = c; last[j] = wt(j);
        end
    end
    chk($sformatf("done count v%0d", vi), done_cnt, 1);
    chk($sformatf("done cycle v%0d", vi), done_cyc, TAPS + 3);
    chk($sformatf("busy rise v%0d", vi), busy_rise, 1);
    chk($sformatf("busy fall v%0d", vi), busy_fall, TAPS + 4);
    for (int j = 0; j < TAPS; j++) begin
      e = (j == v.k) ? v.exp_k : v.exp_all;
      chk($sformatf("w[%0d] v%0d", j, vi), wt(j), e);
      if (e != prev[j])
        chk($sformatf("w[%0d] edge v%0d", j, vi), chg_cyc[j], j + 3);
      chk($sformatf("w[%0d] changes v%0d", j, vi), chg_cnt[j], (e != prev[j]) ? 1 : 0);
    end
  endtask

  initial begin
    int dcnt;
    //          clr  both inj  err    norm           base  k  kv     exp_all exp_k
    tv[0]  = '{1'b1, 1'b0, 1'b0,    -1, 32'd1024,        0, 0,     1,   0,     -1};
    tv[1]  = '{1'b0, 1'b1, 1'b0,    16, 32'd1024,       64, 0,    64,  64,     63};
    tv[2]  = '{1'b0, 1'b0, 1'b1,   -16, 32'd1024,       64, 0,    64,   0,     -1};
    tv[3]  = '{1'b0, 1'b0, 1'b0,    16, 32'd2048,       64, 0,    64,  32,     31};
    tv[4]  = '{1'b0, 1'b0, 1'b0,    16, 32'd2047,       64, 0,    64,  96,     95};
    tv[5]  = '{1'b0, 1'b0, 1'b0,   100, 32'd0,         100, 0,   100,  96,     95};
    tv[6]  = '{1'b1, 1'b0, 1'b0,  4095, 32'd8,           0, 3,     1,   0,  32760};
    tv[7]  = '{1'b0, 1'b0, 1'b0,  8191, 32'd1,           0, 3,  8191,   0,  32767};
    tv[8]  = '{1'b1, 1'b0, 1'b0, -4095, 32'd8,           0, 3,     1,   0, -32760};
    tv[9]  = '{1'b0, 1'b0, 1'b0, -8192, 32'd1,           0, 3,  8191,   0, -32768};
    tv[10] = '{1'b0, 1'b0, 1'b0,  8191, 32'h8000_0000, 8191, 3,  8191,   1, -32767};
    tv[11] = '{1'b0, 1'b0, 1'b0, -8192, 32'hFFFF_FFFF, 8191, 3, -8192,  -1, -32765};

    bus.start = 1'b0; bus.wclr = 1'b0; bus.err = '0; bus.norm = '0; bus.ref_flat = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset w_flat zero", longint'(bus.w_flat == '0), 1);
    chk("reset busy", longint'(bus.busy), 0);
    chk("reset done", longint'(bus.done), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", longint'(bus.busy), 0);
    chk("idle done", longint'(bus.done), 0);
    chk("idle w_flat zero", longint'(bus.w_flat == '0), 1);

    for (int i = 0; i < 12; i++) run_pass(i);

    // mid-pass reset: launch a pass, pull rstn low at cycle 20
    @(negedge clk);
    bus.err = 14'(16); bus.norm = 32'd1024;
    for (int i = 0; i < TAPS; i++) bus.ref_flat[i*REF_W +: REF_W] = 14'(64);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midpass busy before rst", longint'(bus.busy), 1);
    rstn = 1'b0;
    #1;
    chk("midpass rst w_flat zero", longint'(bus.w_flat == '0), 1);
    chk("midpass rst busy", longint'(bus.busy), 0);
    chk("midpass rst done", longint'(bus.done), 0);
    @(negedge clk);
    rstn = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("after rst no done/busy", dcnt, 0);
    chk("after rst w_flat zero", longint'(bus.w_flat == '0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nlms_weight_update.md
Name: nlms_weight_update

Overview:
Owns the adaptive filter's tap-weight registers and writes them back after each filter pass, using a normalised-LMS update driven by the error and reference energy from the adaptive filter.
- Per tap: w[i] <= sat(w[i] + ((err*ref[i]) <<< FRAC) >>> (MU_SHIFT + nshift)).
- nshift = floor(log2(norm)), a power-of-two approximation of division by norm.
- Taps are processed serially, one per cycle, through a 2-stage pipeline.
- w_flat drives the filter's weight inputs directly.

Parameters:
- TAPS, 32, number of weights (tap index 0..TAPS-1).
- REF_W, 14, reference sample width, signed.
- E_W, 14, error width, signed.
- W_W, 16, weight width, signed.
- N_W, 32, energy width, unsigned.
- FRAC, 10, fractional bits of weights (matches the filter's >>10 output scaling).
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  request one update pass; sampled only in IDLE.
- wclr  in  1  zero all weights; sampled only in IDLE.
- err  in  E_W  signed error sample; captured on start.
- norm  in  N_W  reference energy sum(x^2); captured on start.
- ref_flat  in  TAPS*REF_W  reference samples, tap i at [i*REF_W +: REF_W]; must be held stable from start until done.
- w_flat  out  TAPS*W_W  weight registers, tap i at [i*W_W +: W_W].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle registered pulse at the end of a pass.

Behaviour:
Reset:
- Reset is rstn: asynchronous, active-low. Clock is clk.
- Reset values: all weights 0, busy 0, done 0, state IDLE, tap counter 0.
- Reset asserted mid-pass aborts the pass immediately. Weights become 0 and no done pulse follows.

FSM: IDLE -> CAPT -> UPD -> FIN -> IDLE.
- IDLE:
  - start=1: latch err and norm, go to CAPT.
  - else wclr=1: all weights go to 0 next edge; stay in IDLE.
  - start has priority over wclr when both are high.
- CAPT (1 cycle):
  - Compute nshift = index of the MSB set in norm_q (0..31), register it.
  - Set skip = (norm_q == 0).
- UPD (TAPS+1 cycles, tap counter k = 0..TAPS):
  - Stage 1 (k < TAPS): p <= err_q * ref[k], signed, E_W+REF_W bits. Also register the tap index.
  - Stage 2 (k >= 1): for tap j = k-1:
    - delta = (p sign-extended to 48 bits <<< FRAC) >>> (MU_SHIFT + nshift), arithmetic shift, i.e. floor.
    - s = w[j] + delta.
    - w[j] <= saturate s to [-2^(W_W-1), 2^(W_W-1)-1].
    - When skip=1, no write occurs; weights are unchanged.
- FIN (1 cycle): done=1, then return to IDLE.

Timing and handshake:
- Latency: with start sampled at edge 0, done is high during cycle TAPS+3 (cycle 35 for TAPS=32).
- Tap j's w_flat slice changes at edge j+3.
- start or wclr while busy=1 is ignored, not queued.
- The filter must not use w_flat while busy=1, because weights update progressively.
- Only weight j may change on a given edge; all other weights hold.
- Saturation is applied per tap. A saturated tap does not affect the other taps.
- No divider and no state beyond w, the pipeline registers and the FSM.

Test Plan:
- Reset: rstn=0 -> w_flat all 0, busy=0, done=0. Release rstn with start=0 -> state holds.
- Basic update, norm=1024 (nshift=10), err=16, all ref=64, weights 0: product 1024, delta = 1024*1024>>>14 = 64 -> all weights 64. busy rises at edge 1, done high cycle 35 only, busy low cycle 36.
- Floor rounding: err=-1, ref[0]=1, others 0, norm=1024 -> w[0]=-1, others unchanged. Then err=-16, ref all 64 from weights 64 -> all 0.
- Saturation, norm=1:
  - w[3]=32760, err=8191, ref[3]=8191 -> w[3]=32767.
  - err=-8192, ref[3]=8191, w[3]=-32760 -> w[3]=-32768.
- norm=0 with err=100, ref=100 -> weights unchanged, done still pulses at cycle 35.
- Protocol checks:
  - start and wclr pulsed at cycle 10 of a pass -> both ignored, pass completes normally.
  - wclr in IDLE -> all weights 0 next edge.
  - rstn pulsed low at cycle 20 -> weights 0, IDLE, no done pulse.
